// File: rtl/tdc_measure_ctrl.sv
// Measurement sequencer for one TDC channel: arm, coarse count between start/stop hits, fine-bin merge, valid/ready result.
// Optional macro TDC_TIMEOUT_EN adds a coarse-count timeout abort (err_timeout); without it err_timeout is tied 0.
module tdc_measure_ctrl #(
  parameter int BITS_DECO    = 8,
  parameter int BINS_PER_CLK = 200,
  parameter int COARSE_BITS  = 12,
  parameter int RES_BITS     = 21,
  parameter int TIMEOUT_CYC  = 4000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   start_hit,
  input  logic [BITS_DECO-1:0]   start_bin,
  input  logic                   stop_hit,
  input  logic [BITS_DECO-1:0]   stop_bin,
  output logic                   clr_capture,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RES_BITS-1:0]    res_data,
  output logic [COARSE_BITS-1:0] res_coarse,
  output logic                   err_order,
  output logic                   err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_CALC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [RES_BITS-1:0] BPC = RES_BITS'(BINS_PER_CLK);

  state_t                   state_q, state_d;
  logic [BITS_DECO-1:0]     start_bin_q, start_bin_d;
  logic [BITS_DECO-1:0]     stop_bin_q, stop_bin_d;
  logic [COARSE_BITS-1:0]   coarse_q, coarse_d;
  logic [COARSE_BITS-1:0]   coarse_inc;
  logic                     clr_capture_q, clr_capture_d;
  logic [RES_BITS-1:0]      res_data_q, res_data_d;
  logic [COARSE_BITS-1:0]   res_coarse_q, res_coarse_d;
  logic                     err_order_q, err_order_d;
  logic [RES_BITS-1:0]      interval;

`ifdef TDC_TIMEOUT_EN
  localparam logic [COARSE_BITS-1:0] TMO = COARSE_BITS'(TIMEOUT_CYC);
  logic err_timeout_q, err_timeout_d;
`endif

  // Saturating increment: a runaway measurement parks at all-ones.
  assign coarse_inc = (coarse_q == '1) ? coarse_q : coarse_q + 1'b1;

  // Start bin counts back from the start edge, stop bin from the stop edge.
  assign interval = RES_BITS'(coarse_q) * BPC
                  + RES_BITS'(start_bin_q)
                  - RES_BITS'(stop_bin_q);

  always_comb begin
    state_d       = state_q;
    start_bin_d   = start_bin_q;
    stop_bin_d    = stop_bin_q;
    coarse_d      = coarse_q;
    clr_capture_d = 1'b0;
    res_data_d    = res_data_q;
    res_coarse_d  = res_coarse_q;
    err_order_d   = err_order_q;
`ifdef TDC_TIMEOUT_EN
    err_timeout_d = err_timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d       = S_ARMED;
          clr_capture_d = 1'b1;
`ifdef TDC_TIMEOUT_EN
          err_timeout_d = 1'b0;
`endif
        end
      end

      S_ARMED: begin
        if (start_hit) begin
          start_bin_d = start_bin;
          coarse_d    = '0;
          if (stop_hit) begin
            stop_bin_d = stop_bin;
            state_d    = S_CALC;
          end else begin
            state_d    = S_RUN;
          end
        end
      end

      S_RUN: begin
        // The stop edge closes the last clock period, so it is counted too.
        coarse_d = coarse_inc;
        if (stop_hit) begin
          stop_bin_d = stop_bin;
          state_d    = S_CALC;
        end
`ifdef TDC_TIMEOUT_EN
        else if (coarse_inc == TMO) begin
          err_timeout_d = 1'b1;
          state_d       = S_CALC;
        end
`endif
      end

      S_CALC: begin
        res_coarse_d = coarse_q;
        res_data_d   = interval;
        err_order_d  = 1'b0;
        if ((coarse_q == '0) && (stop_bin_q > start_bin_q)) begin
          res_data_d  = '0;
          err_order_d = 1'b1;
        end
`ifdef TDC_TIMEOUT_EN
        if (err_timeout_q) begin
          res_data_d = '0;
        end
`endif
        state_d = S_DONE;
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      start_bin_q   <= '0;
      stop_bin_q    <= '0;
      coarse_q      <= '0;
      clr_capture_q <= 1'b0;
      res_data_q    <= '0;
      res_coarse_q  <= '0;
      err_order_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_bin_q   <= start_bin_d;
      stop_bin_q    <= stop_bin_d;
      coarse_q      <= coarse_d;
      clr_capture_q <= clr_capture_d;
      res_data_q    <= res_data_d;
      res_coarse_q  <= res_coarse_d;
      err_order_q   <= err_order_d;
    end
  end

`ifdef TDC_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign clr_capture = clr_capture_q;
  assign busy        = (state_q != S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign res_data    = res_data_q;
  assign res_coarse  = res_coarse_q;
  assign err_order   = err_order_q;

endmodule
